// File: rtl/interrupt_arbiter.sv
// -----------------------------------------------------------------------------
// interrupt_arbiter
// Collects the UART event sources (overrun, parity, frame error, config done,
// RX threshold), masks them with the ISR enable bits, latches them as pending
// and presents one interrupt at a time to the CPU in fixed priority order.
// The served ID is written into ISR.INTID through a one-cycle load strobe;
// service completes on a rising edge of ISR.IACK, after which NONE is written
// back and interrupt_o stays low for a quiet gap before the next service.
// -----------------------------------------------------------------------------
module interrupt_arbiter #(
  parameter int GAP_CYCLES = 2  // low cycles between two served interrupts (>=1)
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       overrun_error_i,
  input  logic       parity_error_i,
  input  logic       frame_error_i,
  input  logic       config_done_i,
  input  logic       rx_threshold_i,
  input  logic       overrun_error_en_i,
  input  logic       parity_error_en_i,
  input  logic       frame_error_en_i,
  input  logic       rx_rdy_en_i,
  input  logic       int_ackn_i,
  output logic       interrupt_o,
  output logic [2:0] interrupt_id_o,
  output logic       interrupt_id_en_o
);

  // Pending vector bit positions; the ID of a source is its bit index + 1.
  localparam int SRC_OVR = 0;
  localparam int SRC_PAR = 1;
  localparam int SRC_FRM = 2;
  localparam int SRC_CFG = 3;
  localparam int SRC_RX  = 4;
  localparam int SRC_N   = 5;

  localparam logic [2:0] ID_NONE  = 3'b000;
  localparam logic [2:0] ID_OVR   = 3'b001;
  localparam logic [2:0] ID_PAR   = 3'b010;
  localparam logic [2:0] ID_FRM   = 3'b011;
  localparam logic [2:0] ID_CFG   = 3'b100;
  localparam logic [2:0] ID_RXRDY = 3'b101;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SERVE = 2'd1;
  localparam logic [1:0] S_CLEAR = 2'd2;
  localparam logic [1:0] S_GAP   = 2'd3;

  localparam int CNT_W = $clog2(GAP_CYCLES + 1);

  // Registered state
  logic [SRC_N-1:0] r_pend;
  logic             r_rxrdy_armed;
  logic             r_ack_q;
  logic             r_cfg_q;
  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_int;
  logic [2:0]       r_id;
  logic             r_id_en;

  // Combinational helpers
  logic             w_ack;
  logic             w_ack_srv;
  logic             w_cfg_evt;
  logic [3:0]       w_edge_evt;
  logic [3:0]       w_edge_en;
  logic [SRC_N-1:0] w_clr;
  logic [SRC_N-1:0] w_pend_nxt;
  logic             w_armed_nxt;
  logic [2:0]       w_top_id;

  // Rising-edge detection of the acknowledge level and the config handshake.
  assign w_ack     = int_ackn_i & ~r_ack_q;
  assign w_cfg_evt = config_done_i & ~r_cfg_q;

  // An acknowledge only retires something while an interrupt is in service.
  assign w_ack_srv = w_ack & (r_state == S_SERVE);

  // Edge-type sources and their enables; configuration events cannot be masked.
  assign w_edge_evt = {w_cfg_evt, frame_error_i, parity_error_i, overrun_error_i};
  assign w_edge_en  = {1'b1, frame_error_en_i, parity_error_en_i, overrun_error_en_i};

  // One-hot clear for the pending bit of the interrupt being acknowledged.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    w_clr = '0;
    if (w_ack_srv) begin
      case (r_id)
        ID_OVR:   w_clr[SRC_OVR] = 1'b1;
        ID_PAR:   w_clr[SRC_PAR] = 1'b1;
        ID_FRM:   w_clr[SRC_FRM] = 1'b1;
        ID_CFG:   w_clr[SRC_CFG] = 1'b1;
        ID_RXRDY: w_clr[SRC_RX]  = 1'b1;
        default:  w_clr = '0;
      endcase
    end
  end

  // Next pending vector: a new enabled event beats a same-cycle ack clear,
  // a masked event is dropped, and dropping an enable drops its pending bit.
  always_comb begin
    w_pend_nxt[3:0]    = (r_pend[3:0] & w_edge_en & ~w_clr[3:0])
                       | (w_edge_evt & w_edge_en);
    w_pend_nxt[SRC_RX] = rx_threshold_i & rx_rdy_en_i & r_rxrdy_armed
                       & ~w_clr[SRC_RX];
    // RX ready is level-based: it disarms once acknowledged and re-arms only
    // after the FIFO occupancy has fallen below the threshold.
    w_armed_nxt        = ~rx_threshold_i | (r_rxrdy_armed & ~w_clr[SRC_RX]);
  end

  // Fixed-priority selection: OVR > PAR > FRM > CFG > RXRDY.
  always_comb begin
    w_top_id = ID_NONE;
    if      (r_pend[SRC_OVR]) w_top_id = ID_OVR;
    else if (r_pend[SRC_PAR]) w_top_id = ID_PAR;
    else if (r_pend[SRC_FRM]) w_top_id = ID_FRM;
    else if (r_pend[SRC_CFG]) w_top_id = ID_CFG;
    else if (r_pend[SRC_RX])  w_top_id = ID_RXRDY;
  end

  // Edge-detect history registers; config starts high so a handshake that is
  // already complete out of reset does not raise an interrupt.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      // NOTE: registers are updated with non-blocking assignments so every
      // always_ff block sees the pre-edge value of every other register.
      r_ack_q <= 1'b0;
      r_cfg_q <= 1'b1;
    end else begin
      r_ack_q <= int_ackn_i;
      r_cfg_q <= config_done_i;
    end
  end

  // Pending bits and the RX-ready arming flag.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_pend        <= '0;
      r_rxrdy_armed <= 1'b1;
    end else begin
      r_pend        <= w_pend_nxt;
      r_rxrdy_armed <= w_armed_nxt;
    end
  end

  // Service sequencer with registered outputs:
  // IDLE -> SERVE (ID + strobe) -> CLEAR (NONE + strobe) -> GAP -> IDLE.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_int   <= 1'b0;
      r_id    <= ID_NONE;
      r_id_en <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_id_en <= 1'b0;
          if (|r_pend) begin
            r_state <= S_SERVE;
            r_int   <= 1'b1;
            r_id    <= w_top_id;
            r_id_en <= 1'b1;
          end
        end
        S_SERVE: begin
          // The served ID is held even if its enable or pending bit drops;
          // only an acknowledge ends service.
          r_id_en <= 1'b0;
          if (w_ack) begin
            r_state <= S_CLEAR;
            r_int   <= 1'b0;
            r_id    <= ID_NONE;
            r_id_en <= 1'b1;
          end
        end
        S_CLEAR: begin
          r_id_en <= 1'b0;
          r_cnt   <= CNT_W'(GAP_CYCLES - 1);
          // CLEAR already counts as the first quiet cycle.
          if (GAP_CYCLES > 1) r_state <= S_GAP;
          else                r_state <= S_IDLE;
        end
        S_GAP: begin
          r_id_en <= 1'b0;
          if (r_cnt <= CNT_W'(1)) begin
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_int   <= 1'b0;
          r_id    <= ID_NONE;
          r_id_en <= 1'b0;
        end
      endcase
    end
  end

  assign interrupt_o       = r_int;
  assign interrupt_id_o    = r_id;
  assign interrupt_id_en_o = r_id_en;

endmodule

// File: tb/tb_interrupt_arbiter.sv
// -----------------------------------------------------------------------------
// tb_interrupt_arbiter
// Directed stimulus against interrupt_arbiter. A behavioural model of the
// interrupt rules runs alongside and is compared every cycle; literal
// expectations at key points pin both the DUT and the model.
// -----------------------------------------------------------------------------
module tb_interrupt_arbiter;

  localparam int GAP = 2;

  logic       clk_i = 1'b0;
  logic       rst_n_i;
  logic       overrun_error_i, parity_error_i, frame_error_i;
  logic       config_done_i, rx_threshold_i;
  logic       overrun_error_en_i, parity_error_en_i, frame_error_en_i, rx_rdy_en_i;
  logic       int_ackn_i;
  logic       interrupt_o;
  logic [2:0] interrupt_id_o;
  logic       interrupt_id_en_o;

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_en  = 1'b0;

  interrupt_arbiter #(.GAP_CYCLES(GAP)) dut (
    .clk_i              (clk_i),
    .rst_n_i            (rst_n_i),
    .overrun_error_i    (overrun_error_i),
    .parity_error_i     (parity_error_i),
    .frame_error_i      (frame_error_i),
    .config_done_i      (config_done_i),
    .rx_threshold_i     (rx_threshold_i),
    .overrun_error_en_i (overrun_error_en_i),
    .parity_error_en_i  (parity_error_en_i),
    .frame_error_en_i   (frame_error_en_i),
    .rx_rdy_en_i        (rx_rdy_en_i),
    .int_ackn_i         (int_ackn_i),
    .interrupt_o        (interrupt_o),
    .interrupt_id_o     (interrupt_id_o),
    .interrupt_id_en_o  (interrupt_id_en_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model. Sources are numbered 1..5 (= their interrupt ID).
  // m_quiet counts the remaining low cycles after an acknowledge before a new
  // interrupt may be picked up.
  // ---------------------------------------------------------------------------
  bit       m_pend [1:5];
  bit       m_armed, m_ack_prev, m_cfg_prev, m_serving, m_strobe;
  int       m_quiet;
  int       m_id;

  always @(posedge clk_i or negedge rst_n_i) begin
    bit ack, ev, en, any;
    bit nxt [1:5];
    int retire, pick;
    if (!rst_n_i) begin
      for (int s = 1; s <= 5; s++) m_pend[s] = 1'b0;
      m_armed    = 1'b1;
      m_ack_prev = 1'b0;
      m_cfg_prev = 1'b1;
      m_serving  = 1'b0;
      m_strobe   = 1'b0;
      m_quiet    = 0;
      m_id       = 0;
    end else begin
      ack    = int_ackn_i && !m_ack_prev;
      retire = (m_serving && ack) ? m_id : 0;
      // Edge sources 1..4
      for (int s = 1; s <= 4; s++) begin
        case (s)
          1: begin ev = overrun_error_i; en = overrun_error_en_i; end
          2: begin ev = parity_error_i;  en = parity_error_en_i;  end
          3: begin ev = frame_error_i;   en = frame_error_en_i;   end
          default: begin ev = config_done_i && !m_cfg_prev; en = 1'b1; end
        endcase
        if (!en)              nxt[s] = 1'b0;
        else if (ev)          nxt[s] = 1'b1;
        else if (retire == s) nxt[s] = 1'b0;
        else                  nxt[s] = m_pend[s];
      end
      // RX ready level source
      nxt[5] = rx_threshold_i && rx_rdy_en_i && m_armed && (retire != 5);
      if (!rx_threshold_i)   m_armed = 1'b1;
      else if (retire == 5)  m_armed = 1'b0;
      // Service progress, decided on the pre-edge pending set
      any  = 1'b0;
      pick = 0;
      for (int s = 5; s >= 1; s--) if (m_pend[s]) begin any = 1'b1; pick = s; end
      m_strobe = 1'b0;
      if (m_serving) begin
        if (ack) begin
          m_serving = 1'b0;
          m_id      = 0;
          m_quiet   = GAP;
          m_strobe  = 1'b1;
        end
      end else if (m_quiet > 0) begin
        m_quiet--;
      end else if (any) begin
        m_serving = 1'b1;
        m_id      = pick;
        m_strobe  = 1'b1;
      end
      for (int s = 1; s <= 5; s++) m_pend[s] = nxt[s];
      m_ack_prev = int_ackn_i;
      m_cfg_prev = config_done_i;
    end
  end

  // Cycle-by-cycle comparison, sampled just after the active edge settles.
  always @(posedge clk_i) begin
    #1;
    if (cmp_en) begin
      check("cmp_int",    {7'd0, interrupt_o},       {7'd0, m_serving});
      check("cmp_id",     {5'd0, interrupt_id_o},    8'(m_id));
      check("cmp_strobe", {7'd0, interrupt_id_en_o}, {7'd0, m_strobe});
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic expect_out(input string name, input logic i, input logic [2:0] id, input logic st);
    check({name, "_int"},    {7'd0, interrupt_o},       {7'd0, i});
    check({name, "_id"},     {5'd0, interrupt_id_o},    {5'd0, id});
    check({name, "_strobe"}, {7'd0, interrupt_id_en_o}, {7'd0, st});
  endtask

  // Raise IACK for one cycle; returns in the cycle after the ack edge.
  task automatic do_ack();
    int_ackn_i = 1'b1;
    tick();
    int_ackn_i = 1'b0;
  endtask

  initial begin
    rst_n_i            = 1'b0;
    overrun_error_i    = 1'b0;
    parity_error_i     = 1'b0;
    frame_error_i      = 1'b0;
    config_done_i      = 1'b0;
    rx_threshold_i     = 1'b0;
    overrun_error_en_i = 1'b1;
    parity_error_en_i  = 1'b1;
    frame_error_en_i   = 1'b1;
    rx_rdy_en_i        = 1'b1;
    int_ackn_i         = 1'b0;

    tick(2);
    expect_out("reset", 1'b0, 3'b000, 1'b0);
    check("reset_model_id", 8'(m_id), 8'd0);
    rst_n_i = 1'b1;
    cmp_en  = 1'b1;

    // Overrun: pending after one edge, interrupt and strobe after two.
    tick();
    overrun_error_i = 1'b1;
    tick();
    overrun_error_i = 1'b0;
    expect_out("ovr_pend", 1'b0, 3'b000, 1'b0);
    tick();
    expect_out("ovr_raise", 1'b1, 3'b001, 1'b1);
    check("ovr_model_id", 8'(m_id), 8'd1);
    tick();
    expect_out("ovr_hold", 1'b1, 3'b001, 1'b0);
    do_ack();
    expect_out("ovr_clear", 1'b0, 3'b000, 1'b1);
    tick();
    expect_out("ovr_gap", 1'b0, 3'b000, 1'b0);
    tick();
    expect_out("ovr_idle", 1'b0, 3'b000, 1'b0);
    tick();

    // Parity and frame error together: parity first, frame after the gap.
    parity_error_i = 1'b1;
    frame_error_i  = 1'b1;
    tick();
    parity_error_i = 1'b0;
    frame_error_i  = 1'b0;
    tick();
    expect_out("par_raise", 1'b1, 3'b010, 1'b1);
    tick();
    do_ack();
    expect_out("par_clear", 1'b0, 3'b000, 1'b1);
    tick(3);
    expect_out("frm_raise", 1'b1, 3'b011, 1'b1);
    check("frm_model_id", 8'(m_id), 8'd3);
    do_ack();
    tick(4);
    expect_out("frm_done", 1'b0, 3'b000, 1'b0);

    // Masked frame error is dropped, enabling later does not revive it.
    frame_error_en_i = 1'b0;
    frame_error_i    = 1'b1;
    tick();
    frame_error_i    = 1'b0;
    tick(4);
    expect_out("frm_masked", 1'b0, 3'b000, 1'b0);
    frame_error_en_i = 1'b1;
    tick(4);
    expect_out("frm_dropped", 1'b0, 3'b000, 1'b0);

    // RX threshold level: served once, no re-raise while still high.
    rx_threshold_i = 1'b1;
    tick(2);
    expect_out("rx_raise", 1'b1, 3'b101, 1'b1);
    tick();
    do_ack();
    tick(6);
    expect_out("rx_no_reraise", 1'b0, 3'b000, 1'b0);
    rx_threshold_i = 1'b0;
    tick();
    rx_threshold_i = 1'b1;
    tick(2);
    expect_out("rx_rearm", 1'b1, 3'b101, 1'b1);

    // Overrun while RX ready is served: no preemption, served after the gap.
    overrun_error_i = 1'b1;
    tick();
    overrun_error_i = 1'b0;
    tick(3);
    expect_out("rx_no_preempt", 1'b1, 3'b101, 1'b0);
    do_ack();
    tick(3);
    expect_out("ovr_after_rx", 1'b1, 3'b001, 1'b1);
    tick();

    // New overrun in the same cycle as its ack: set wins, served again.
    overrun_error_i = 1'b1;
    int_ackn_i      = 1'b1;
    tick();
    overrun_error_i = 1'b0;
    int_ackn_i      = 1'b0;
    expect_out("ovr_set_ack_clear", 1'b0, 3'b000, 1'b1);
    tick(3);
    expect_out("ovr_reserved", 1'b1, 3'b001, 1'b1);
    tick();

    // Asynchronous reset during service.
    rst_n_i        = 1'b0;
    rx_threshold_i = 1'b0;
    #1;
    expect_out("async_reset", 1'b0, 3'b000, 1'b0);
    tick(2);
    rst_n_i = 1'b1;
    tick(4);
    expect_out("post_reset", 1'b0, 3'b000, 1'b0);

    // Config handshake edge; a parity event whose enable drops before it is
    // served is discarded.
    config_done_i = 1'b1;
    tick(2);
    expect_out("cfg_raise", 1'b1, 3'b100, 1'b1);
    parity_error_i = 1'b1;
    tick();
    parity_error_i    = 1'b0;
    parity_error_en_i = 1'b0;
    tick();
    do_ack();
    tick(5);
    expect_out("par_disabled", 1'b0, 3'b000, 1'b0);
    parity_error_en_i = 1'b1;
    tick(2);

    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
